bcd_entry_ctrl: RTL and testbench
=================================

Name: bcd_entry_ctrl

Overview:
- Upstream feeder for the BCD calculator ALU.
- Accepts keypad key events and assembles two packed-BCD operands plus an opcode; these drive the combinational ALU directly.
- On '=', latches the ALU result for the display stage.
- Supports chaining: an operator pressed after '=' makes the latched result the new first operand.

Parameters:
NUM_DIGITS, 2, BCD digits per operand; operand/result width W = 4*NUM_DIGITS+1 (bit W-1 = carry/sign)

Ports:
clk  input  1  system clock, all state updates on rising edge
nrst  input  1  asynchronous active-low reset
key_strobe  input  1  key event qualifier; one-cycle pulse, synchronous to clk (see KEY_SYNC_EN)
key_code  input  4  0-9 digit; 10 add; 11 sub; 12 equals; 13 clear; 14-15 reserved
alu_result  input  W  result from ALU: {carry/sign, BCD digits}
op1  output  W  first operand to ALU; bit W-1 always 0
op2  output  W  second operand to ALU; bit W-1 always 0
opcode  output  3  3'b001 add, 3'b010 sub, 3'b000 none
disp_val  output  W  value for the display stage: operand being entered, or latched result
result_valid  output  1  high while in RESULT state
entry_err  output  1  sticky; set on a rejected key, cleared by clear/reset

Behaviour:
- Reset (async, nrst=0): op1=op2=disp_val=0, opcode=3'b000, result_valid=0, entry_err=0, state=OP1.
- Key handling:
  - A key is consumed on the rising edge where key_strobe=1.
  - Codes 14-15 are ignored; no state change and no error.
  - Only one key is processed per cycle.
- States: OP1, OP2, RESULT.
- Digit key d:
  - In OP1, shift into op1: op1[4*NUM_DIGITS-1:0] = {op1[4*NUM_DIGITS-5:0], d}.
  - In OP2, shift into op2 the same way.
  - A per-operand digit counter (0..NUM_DIGITS) limits entry. A digit arriving when the counter is already NUM_DIGITS is dropped and sets entry_err.
  - In RESULT, a digit starts a new calculation: op1={0,...,d}, op2=0, opcode=0, counter=1, state becomes OP1, result_valid falls.
- Operator key (add/sub):
  - In OP1: opcode is set, state becomes OP2, op2=0, op2 counter=0.
  - In OP2 before any op2 digit: only opcode is replaced (operator override).
  - In OP2 after at least one digit: ignored, and entry_err is set.
  - In RESULT with latched result bit W-1 = 0: op1 = latched result, op2=0, opcode set, state becomes OP2 (chaining).
  - In RESULT with bit W-1 = 1 (overflow or negative ten's complement): ignored, and entry_err is set.
- Equals key:
  - In OP2 with opcode != 0: on the same edge, latch alu_result into the result register, state becomes RESULT, result_valid rises the next cycle. The ALU is combinational, so latency is zero cycles from key to sample.
  - With an empty op2, op2 counts as 0.
  - In OP1 or RESULT: ignored, no error.
- Clear key: from any state, same values as reset.
- disp_val:
  - OP1 shows op1.
  - OP2 shows op2 once at least one op2 digit is entered; otherwise it shows op1.
  - RESULT shows the latched result, all W bits.
- Widths:
  - Operands are never wider than NUM_DIGITS BCD digits, and bit W-1 of op1/op2 is forced to 0.
  - No binary arithmetic is performed here.
- Reset mid-entry: async clear takes effect immediately; any partial operand is lost.
- Simultaneous strobe and reset: reset wins.

Optional Feature:
- Macro: KEY_SYNC_EN.
- Defined:
  - key_strobe may be an asynchronous level (held high per press).
  - Two-flop synchronizer followed by a rising-edge detector yields one internal event per press.
  - key_code is sampled alongside the detected edge.
  - Adds 2 cycles of latency from press to state update.
  - Holding the key produces no repeats.
- Undefined: key_strobe is used directly as a synchronous one-cycle pulse; every cycle with key_strobe=1 is a separate key.

Test Plan:
- Reset then keys 3,7,+,1,2,= with ALU returning 9'b0_0100_1001 → op1=9'b0_0011_0111, op2=9'b0_0001_0010, opcode=001, disp_val=9'b0_0100_1001, result_valid=1 the next cycle.
- Keys 2,1,-,3,3,= with ALU returning 9'b1_1000_1000 → opcode=010, result latched as 9'b1_1000_1000; then key + → ignored, entry_err=1, state stays RESULT.
- Keys 8,6,5 → op1=9'b0_1000_0110, third digit dropped, entry_err=1; then clear → all outputs 0, entry_err=0.
- Chaining: 1,5,+,0,5,= with ALU returning 9'b0_0010_0000, then -,0,3 → op1=9'b0_0010_0000, op2=9'b0_0000_0011, opcode=010.
- Operator override: 4,+,- → opcode=010, state OP2, disp_val=9'b0_0000_0100; key_code=14 strobes cause no change.
- nrst asserted mid-entry (after 4,+,7), asynchronously between clock edges → outputs 0 immediately, state OP1; next digit 9 gives op1=9'b0_0000_1001.

Source files
------------

// File: rtl/bcd_entry_ctrl.sv
// bcd_entry_ctrl
// Keypad front end for the BCD calculator ALU. Key events build two packed-BCD
// operands and an opcode that drive the combinational ALU directly. The '='
// key captures the ALU result for the display stage. An operator pressed
// after '=' reuses that result as the next first operand.
//
// Optional feature, macro KEY_SYNC_EN:
//   defined   - key_strobe is an asynchronous level that is held high for each
//               press. It passes through a two-flop synchronizer and a
//               rising-edge detector, which gives one event per press and two
//               extra cycles of latency.
//   undefined - key_strobe is a synchronous one-cycle pulse. Every cycle in
//               which it is high counts as one key.
//
// Ports:
//   clk          system clock, rising edge
//   nrst         asynchronous active-low reset
//   key_strobe   key event qualifier
//   key_code     0-9 digit, 10 add, 11 sub, 12 equals, 13 clear, 14-15 reserved
//   alu_result   {carry/sign, BCD digits} from the ALU
//   op1, op2     operands to the ALU (MSB always 0)
//   opcode       3'b001 add, 3'b010 sub, 3'b000 none
//   disp_val     operand being entered, or the latched result
//   result_valid high while in RESULT
//   entry_err    sticky rejected-key flag, cleared by clear/reset
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_OP1    | entering first operand
// ST_OP2    | operator chosen, entering second operand
// ST_RESULT | ALU result latched and shown; digit restarts, operator chains
module bcd_entry_ctrl #(
    parameter int NUM_DIGITS = 2,
    localparam int W = 4 * NUM_DIGITS + 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         key_strobe,
    input  logic [3:0]   key_code,
    input  logic [W-1:0] alu_result,
    output logic [W-1:0] op1,
    output logic [W-1:0] op2,
    output logic [2:0]   opcode,
    output logic [W-1:0] disp_val,
    output logic         result_valid,
    output logic         entry_err
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_DIGITS);

    typedef enum logic [1:0] {
        ST_OP1    = 2'd0,
        ST_OP2    = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   op1_r;
    logic [DW-1:0]   op2_r;
    logic [CW-1:0]   cnt1;
    logic [CW-1:0]   cnt2;
    logic [W-1:0]    result_r;
    logic            key_evt;

`ifdef KEY_SYNC_EN
    logic [2:0] strobe_sync;

    // Bits [1:0] form the synchronizer. Bit 2 holds the previous synchronized
    // level for the edge detector. key_code is assumed stable while the key
    // is held, so it is sampled directly when the edge is detected.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            strobe_sync <= '0;
        end else begin
            strobe_sync <= {strobe_sync[1:0], key_strobe};
        end
    end

    assign key_evt = strobe_sync[1] & ~strobe_sync[2];
`else
    assign key_evt = key_strobe;
`endif

    logic       is_digit;
    logic       is_op;
    logic [2:0] op_sel;
    logic [DW-1:0] digit_ext;

    assign is_digit  = (key_code < 4'd10);
    assign is_op     = (key_code == 4'd10) || (key_code == 4'd11);
    assign op_sel    = (key_code == 4'd10) ? 3'b001 : 3'b010;
    assign digit_ext = DW'(key_code);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_OP1;
            op1_r     <= '0;
            op2_r     <= '0;
            cnt1      <= '0;
            cnt2      <= '0;
            opcode    <= 3'b000;
            result_r  <= '0;
            entry_err <= 1'b0;
        end else if (key_evt) begin
            if (key_code == 4'd13) begin
                state     <= ST_OP1;
                op1_r     <= '0;
                op2_r     <= '0;
                cnt1      <= '0;
                cnt2      <= '0;
                opcode    <= 3'b000;
                result_r  <= '0;
                entry_err <= 1'b0;
            end else if (is_digit) begin
                case (state)
                    ST_OP1: begin
                        if (cnt1 == CNT_FULL) begin
                            entry_err <= 1'b1;
                        end else begin
                            op1_r <= (op1_r << 4) | digit_ext;
                            cnt1  <= cnt1 + 1'b1;
                        end
                    end
                    ST_OP2: begin
                        if (cnt2 == CNT_FULL) begin
                            entry_err <= 1'b1;
                        end else begin
                            op2_r <= (op2_r << 4) | digit_ext;
                            cnt2  <= cnt2 + 1'b1;
                        end
                    end
                    default: begin
                        state  <= ST_OP1;
                        op1_r  <= digit_ext;
                        cnt1   <= CW'(1);
                        op2_r  <= '0;
                        cnt2   <= '0;
                        opcode <= 3'b000;
                    end
                endcase
            end else if (is_op) begin
                case (state)
                    ST_OP1: begin
                        opcode <= op_sel;
                        state  <= ST_OP2;
                        op2_r  <= '0;
                        cnt2   <= '0;
                    end
                    ST_OP2: begin
                        if (cnt2 == '0) begin
                            opcode <= op_sel;
                        end else begin
                            entry_err <= 1'b1;
                        end
                    end
                    default: begin
                        // A set MSB means carry or a ten's-complement negative.
                        // Neither fits an operand, so the key is refused.
                        if (result_r[W-1]) begin
                            entry_err <= 1'b1;
                        end else begin
                            op1_r  <= result_r[DW-1:0];
                            cnt1   <= CNT_FULL;
                            op2_r  <= '0;
                            cnt2   <= '0;
                            opcode <= op_sel;
                            state  <= ST_OP2;
                        end
                    end
                endcase
            end else if (key_code == 4'd12) begin
                if (state == ST_OP2 && opcode != 3'b000) begin
                    result_r <= alu_result;
                    state    <= ST_RESULT;
                end
            end
        end
    end

    assign op1          = {1'b0, op1_r};
    assign op2          = {1'b0, op2_r};
    assign result_valid = (state == ST_RESULT);

    always_comb begin
        disp_val = {1'b0, op1_r};
        case (state)
            ST_OP2: begin
                if (cnt2 != '0) begin
                    disp_val = {1'b0, op2_r};
                end
            end
            ST_RESULT: disp_val = result_r;
            default:   disp_val = {1'b0, op1_r};
        endcase
    end

endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// Testbench for bcd_entry_ctrl in the default build, where key_strobe is a
// synchronous pulse. A decimal-arithmetic model predicts the outputs after
// each key, and a monitor compares them once the DUT consumes the key.
module tb_bcd_entry_ctrl;

    localparam int N   = 2;
    localparam int W   = 4 * N + 1;
    localparam int DW  = 4 * N;
    localparam int LIM = 10 ** N;

    logic         tb_clk;
    logic         nrst;
    logic         key_strobe;
    logic [3:0]   key_code;
    logic [W-1:0] alu_result;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [2:0]   opcode;
    logic [W-1:0] disp_val;
    logic         result_valid;
    logic         entry_err;

    bcd_entry_ctrl #(.NUM_DIGITS(N)) dut (
        .clk          (tb_clk),
        .nrst         (nrst),
        .key_strobe   (key_strobe),
        .key_code     (key_code),
        .alu_result   (alu_result),
        .op1          (op1),
        .op2          (op2),
        .opcode       (opcode),
        .disp_val     (disp_val),
        .result_valid (result_valid),
        .entry_err    (entry_err)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    typedef struct {
        logic [W-1:0] op1;
        logic [W-1:0] op2;
        logic [2:0]   opc;
        logic [W-1:0] disp;
        logic         rv;
        logic         err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;

    // Reference model. Phase 0 is entering the first number, phase 1 the
    // second number, and phase 2 shows a result.
    int m_phase, m_op1, m_n1, m_op2, m_n2, m_opc, m_res;
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bcd2dec(input int v);
        int r = 0;
        int m = 1;
        for (int i = 0; i < N; i++) begin
            r += ((v >> (4 * i)) & 15) * m;
            m *= 10;
        end
        return r;
    endfunction

    function automatic int dec2bcd(input int d);
        int r = 0;
        int x = d;
        for (int i = 0; i < N; i++) begin
            r |= (x % 10) << (4 * i);
            x /= 10;
        end
        return r;
    endfunction

    // A decimal ALU. The carry is placed above the digits, and a negative
    // difference is shown as its ten's complement with the MSB set.
    function automatic int model_alu();
        int a = bcd2dec(m_op1);
        int b = bcd2dec(m_op2);
        int s;
        if (m_opc == 1) begin
            s = a + b;
            return ((s >= LIM) ? (1 << DW) : 0) | dec2bcd(s % LIM);
        end else if (m_opc == 2) begin
            if (a >= b) return dec2bcd(a - b);
            return (1 << DW) | dec2bcd(LIM + a - b);
        end
        return 0;
    endfunction

    task automatic model_clear();
        m_phase = 0; m_op1 = 0; m_n1 = 0; m_op2 = 0; m_n2 = 0;
        m_opc = 0; m_res = 0; m_err = 0;
    endtask

    task automatic apply_key(input int k);
        int ov;
        ov = (k == 10) ? 1 : 2;
        if (k >= 14) begin
        end else if (k == 13) begin
            model_clear();
        end else if (k <= 9) begin
            if (m_phase == 0) begin
                if (m_n1 == N) m_err = 1;
                else begin m_op1 = (m_op1 * 16 + k) % (16 ** N); m_n1++; end
            end else if (m_phase == 1) begin
                if (m_n2 == N) m_err = 1;
                else begin m_op2 = (m_op2 * 16 + k) % (16 ** N); m_n2++; end
            end else begin
                m_phase = 0; m_op1 = k; m_n1 = 1; m_op2 = 0; m_n2 = 0; m_opc = 0;
            end
        end else if (k <= 11) begin
            if (m_phase == 0) begin
                m_opc = ov; m_phase = 1; m_op2 = 0; m_n2 = 0;
            end else if (m_phase == 1) begin
                if (m_n2 == 0) m_opc = ov;
                else m_err = 1;
            end else begin
                if (m_res >= (1 << DW)) m_err = 1;
                else begin
                    m_op1 = m_res; m_n1 = N; m_op2 = 0; m_n2 = 0; m_opc = ov; m_phase = 1;
                end
            end
        end else begin
            if (m_phase == 1 && m_opc != 0) begin
                m_res = model_alu();
                m_phase = 2;
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.op1  = W'(m_op1);
        e.op2  = W'(m_op2);
        e.opc  = 3'(m_opc);
        e.rv   = (m_phase == 2);
        e.err  = m_err;
        if (m_phase == 2)                  e.disp = W'(m_res);
        else if (m_phase == 1 && m_n2 > 0) e.disp = W'(m_op2);
        else                               e.disp = W'(m_op1);
        sb.push_back(e);
    endtask

    task automatic press(input int k);
        @(posedge tb_clk); #1;
        alu_result = W'(model_alu());
        key_code   = 4'(k);
        key_strobe = 1'b1;
        apply_key(k);
        push_expected();
        @(posedge tb_clk); #1;
        key_strobe = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge tb_clk); #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_op1"}, 32'(op1), 0);
        chk({tag, "_op2"}, 32'(op2), 0);
        chk({tag, "_opcode"}, 32'(opcode), 0);
        chk({tag, "_disp"}, 32'(disp_val), 0);
        chk({tag, "_rv"}, 32'(result_valid), 0);
        chk({tag, "_err"}, 32'(entry_err), 0);
    endtask

    // The monitor compares the outputs after every key the DUT accepts.
    initial begin
        forever begin
            @(posedge tb_clk);
            if (key_strobe === 1'b1 && nrst === 1'b1) begin
                @(negedge tb_clk);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got key with no expectation at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("op1", 32'(op1), 32'(mon_e.op1));
                    chk("op2", 32'(op2), 32'(mon_e.op2));
                    chk("opcode", 32'(opcode), 32'(mon_e.opc));
                    chk("disp_val", 32'(disp_val), 32'(mon_e.disp));
                    chk("result_valid", 32'(result_valid), 32'(mon_e.rv));
                    chk("entry_err", 32'(entry_err), 32'(mon_e.err));
                end
            end
        end
    end

    initial begin
        int r;
        int seq1[6] = '{3, 7, 10, 1, 2, 12};
        int seq2[6] = '{2, 1, 11, 3, 3, 12};
        int seq4[9] = '{1, 5, 10, 0, 5, 12, 11, 0, 3};

        nrst = 1'b0; key_strobe = 1'b0; key_code = 4'd0; alu_result = '0;
        model_clear();
        #12;
        check_all_zero("reset");
        @(negedge tb_clk);
        nrst = 1'b1;

        foreach (seq1[i]) press(seq1[i]);
        wait_idle();
        chk("tp1_op1", 32'(op1), 32'h037);
        chk("tp1_op2", 32'(op2), 32'h012);
        chk("tp1_opcode", 32'(opcode), 32'h1);
        chk("tp1_disp", 32'(disp_val), 32'h049);
        chk("tp1_rv", 32'(result_valid), 1);
        press(13);

        foreach (seq2[i]) press(seq2[i]);
        wait_idle();
        chk("tp2_opcode", 32'(opcode), 32'h2);
        chk("tp2_disp", 32'(disp_val), 32'h188);
        press(10);
        wait_idle();
        chk("tp2_err", 32'(entry_err), 1);
        chk("tp2_rv", 32'(result_valid), 1);
        press(13);

        press(8); press(6); press(5);
        wait_idle();
        chk("tp3_op1", 32'(op1), 32'h086);
        chk("tp3_err", 32'(entry_err), 1);
        press(13);
        wait_idle();
        check_all_zero("tp3_clear");

        foreach (seq4[i]) press(seq4[i]);
        wait_idle();
        chk("tp4_op1", 32'(op1), 32'h020);
        chk("tp4_op2", 32'(op2), 32'h003);
        chk("tp4_opcode", 32'(opcode), 32'h2);
        press(13);

        press(4); press(10); press(11);
        wait_idle();
        chk("tp5_opcode", 32'(opcode), 32'h2);
        chk("tp5_disp", 32'(disp_val), 32'h004);
        chk("tp5_rv", 32'(result_valid), 0);
        press(14); press(15);
        wait_idle();
        chk("tp5_rsv_opcode", 32'(opcode), 32'h2);
        chk("tp5_rsv_disp", 32'(disp_val), 32'h004);
        press(13);

        // Assert reset between clock edges in the middle of entry. Then hold a
        // strobe across an edge while reset is still low.
        press(4); press(10); press(7);
        wait_idle();
        @(posedge tb_clk); #3;
        nrst = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_clear();
        key_code = 4'd9; key_strobe = 1'b1;
        @(posedge tb_clk); #1;
        check_all_zero("rst_wins");
        key_strobe = 1'b0;
        @(negedge tb_clk);
        nrst = 1'b1;
        press(9);
        wait_idle();
        chk("tp6_op1", 32'(op1), 32'h009);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      press($urandom_range(0, 9));
            else if (r < 72) press($urandom_range(10, 11));
            else if (r < 87) press(12);
            else if (r < 93) press(13);
            else             press($urandom_range(14, 15));
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
